// File: rtl/data_mem_unit.sv
// data_mem_unit
//   Data-memory responder for the single-cycle RISC-V core. Serves byte,
//   halfword and word loads/stores on an internal little-endian word array.
//   Accesses that spill into the next word take two word cycles. Load data
//   is sign- or zero-extended. Each request gets a one-cycle response pulse.
//
// Ports
//   clk        : rising-edge clock
//   rst        : synchronous active-high reset (memory contents are kept)
//   req_valid  : request present
//   req_ready  : block can accept a request this cycle
//   MemRW      : 1 = store, 0 = load
//   whb        : access code (loads 0..4 = LB/LH/LW/LBU/LHU, stores 0..2 = SB/SH/SW)
//   addr       : byte address (upper bits beyond the array alias)
//   wdata      : right-aligned store data
//   rsp_valid  : one-cycle response pulse
//   rdata      : extended load data, held between responses
//   err        : illegal access code, valid with rsp_valid
module data_mem_unit #(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        MemRW,
  input  logic [2:0]  whb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        rsp_valid,
  output logic [31:0] rdata,
  output logic        err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC0 = 2'd1,
    ACC1 = 2'd2,
    RESP = 2'd3
  } state_e;

  // Number of bytes moved by an access code (0 for codes with no size).
  function automatic logic [2:0] access_size(input logic [2:0] code);
    case (code)
      3'd0, 3'd3: access_size = 3'd1;
      3'd1, 3'd4: access_size = 3'd2;
      3'd2:       access_size = 3'd4;
      default:    access_size = 3'd0;
    endcase
  endfunction

  // Stores only know SB/SH/SW; loads additionally know LBU/LHU.
  function automatic logic code_legal(input logic is_store, input logic [2:0] code);
    if (is_store) begin
      code_legal = (code <= 3'd2);
    end else begin
      code_legal = (code <= 3'd4);
    end
  endfunction

  // Byte-lane mask for an access of the given size starting at lane 0.
  function automatic logic [3:0] size_mask(input logic [2:0] size);
    case (size)
      3'd1:    size_mask = 4'b0001;
      3'd2:    size_mask = 4'b0011;
      3'd4:    size_mask = 4'b1111;
      default: size_mask = 4'b0000;
    endcase
  endfunction

  // Right-aligned raw load bytes -> architectural register value.
  function automatic logic [31:0] extend_load(input logic [31:0] raw, input logic [2:0] code);
    case (code)
      3'd0:    extend_load = {{24{raw[7]}}, raw[7:0]};
      3'd1:    extend_load = {{16{raw[15]}}, raw[15:0]};
      3'd2:    extend_load = raw;
      3'd3:    extend_load = {24'd0, raw[7:0]};
      3'd4:    extend_load = {16'd0, raw[15:0]};
      default: extend_load = 32'd0;
    endcase
  endfunction

  state_e        state_q, state_d;
  logic          req_ready_q, req_ready_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;
  logic          mem_rw_q, mem_rw_d;
  logic [2:0]    whb_q, whb_d;
  logic [AW+1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   lo_word_q, lo_word_d;

  logic [31:0]   mem_array_q [DEPTH_WORDS];

  logic [AW-1:0] idx0_s;
  logic [AW-1:0] idx1_s;
  logic [AW-1:0] cur_idx_s;
  logic [31:0]   rd_word_s;
  logic [3:0]    span_end_s;
  logic          crosses_s;
  logic [63:0]   lanes_s;
  logic [7:0]    mask_s;
  logic [63:0]   load_pair_s;
  logic [63:0]   load_raw_s;
  logic [31:0]   load_word_s;
  logic          wr_en_s;
  logic [3:0]    wr_lanes_s;
  logic [31:0]   wr_data_s;
  logic [31:0]   wr_word_s;
  logic          unused_bits_s;

  // Second word of a crossing access wraps modulo the array size.
  assign idx0_s      = addr_q[AW+1:2];
  assign idx1_s      = idx0_s + {{(AW-1){1'b0}}, 1'b1};
  assign cur_idx_s   = (state_q == ACC1) ? idx1_s : idx0_s;
  assign rd_word_s   = mem_array_q[cur_idx_s];
  assign span_end_s  = {2'b00, addr_q[1:0]} + {1'b0, access_size(whb_q)};
  assign crosses_s   = (span_end_s > 4'd4);
  // Store bytes and lane enables placed across the two-word window.
  assign lanes_s     = {32'd0, wdata_q} << {addr_q[1:0], 3'b000};
  assign mask_s      = {4'b0000, size_mask(access_size(whb_q))} << addr_q[1:0];
  assign load_raw_s  = load_pair_s >> {addr_q[1:0], 3'b000};
  assign load_word_s = load_raw_s[31:0];

  assign unused_bits_s = ^{addr[31:AW+2], load_raw_s[63:32]};

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rdata     = rdata_q;
  assign err       = err_q;

  // Per-cycle word access: lane selection, read-modify-write merge, load window.
  always_comb begin
    wr_lanes_s  = 4'b0000;
    wr_data_s   = 32'd0;
    load_pair_s = {32'd0, rd_word_s};
    if (state_q == ACC0) begin
      wr_lanes_s = mask_s[3:0];
      wr_data_s  = lanes_s[31:0];
    end else if (state_q == ACC1) begin
      wr_lanes_s  = mask_s[7:4];
      wr_data_s   = lanes_s[63:32];
      load_pair_s = {rd_word_s, lo_word_q};
    end else begin
      wr_lanes_s = 4'b0000;
    end
    // A write on a reset edge is dropped; earlier commits stay.
    wr_en_s = mem_rw_q && !rst && ((state_q == ACC0) || (state_q == ACC1));
    for (int b = 0; b < 4; b++) begin
      wr_word_s[8*b +: 8] = wr_lanes_s[b] ? wr_data_s[8*b +: 8] : rd_word_s[8*b +: 8];
    end
  end

  // Next-state, request capture and response formation.
  always_comb begin
    state_d   = state_q;
    mem_rw_d  = mem_rw_q;
    whb_d     = whb_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    lo_word_d = lo_word_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          mem_rw_d = MemRW;
          whb_d    = whb;
          addr_d   = addr[AW+1:0];
          wdata_d  = wdata;
          if (code_legal(MemRW, whb)) begin
            state_d = ACC0;
          end else begin
            state_d = RESP;
            err_d   = 1'b1;
            rdata_d = 32'd0;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ACC0: begin
        lo_word_d = rd_word_s;
        if (crosses_s) begin
          state_d = ACC1;
        end else begin
          state_d = RESP;
          err_d   = 1'b0;
          rdata_d = mem_rw_q ? 32'd0 : extend_load(load_word_s, whb_q);
        end
      end
      ACC1: begin
        state_d = RESP;
        err_d   = 1'b0;
        rdata_d = mem_rw_q ? 32'd0 : extend_load(load_word_s, whb_q);
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    rsp_valid_d = (state_d == RESP);
    req_ready_d = (state_d == IDLE);
  end

  // Control, request and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= 32'd0;
      err_q       <= 1'b0;
      mem_rw_q    <= 1'b0;
      whb_q       <= 3'd0;
      addr_q      <= '0;
      wdata_q     <= 32'd0;
      lo_word_q   <= 32'd0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      mem_rw_q    <= mem_rw_d;
      whb_q       <= whb_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      lo_word_q   <= lo_word_d;
    end
  end

  // Word array write port; contents are not cleared by reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_array_q[cur_idx_s] <= wr_word_s;
    end
  end

endmodule

// File: tb/tb_data_mem_unit.sv
// tb_data_mem_unit
//   Self-checking bench for data_mem_unit: a directed vector table, a
//   hand-written reset-during-crossing sequence, and randomized traffic
//   compared against a byte-addressed reference memory.
module tb_data_mem_unit;

  localparam int DEPTH = 1024;
  localparam int NB    = DEPTH * 4;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        mem_rw;
  logic [2:0]  whb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        rsp_valid;
  logic [31:0] rdata;
  logic        err;

  int tests;
  int fails;

  logic [7:0] ref_mem [NB];

  data_mem_unit #(.DEPTH_WORDS(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .MemRW     (mem_rw),
    .whb       (whb),
    .addr      (addr),
    .wdata     (wdata),
    .rsp_valid (rsp_valid),
    .rdata     (rdata),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rw;
    logic [2:0]  code;
    logic [31:0] a;
    logic [31:0] d;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs[$];

  // ---------------- reference model (byte-addressed) ----------------
  function automatic int ref_size(input logic [2:0] c);
    case (c)
      3'd0, 3'd3: return 1;
      3'd1, 3'd4: return 2;
      3'd2:       return 4;
      default:    return 0;
    endcase
  endfunction

  function automatic bit ref_legal(input logic rw, input logic [2:0] c);
    return rw ? (c < 3'd3) : (c < 3'd5);
  endfunction

  function automatic int ref_lat(input logic rw, input logic [2:0] c, input logic [31:0] a);
    if (!ref_legal(rw, c)) return 1;
    if (int'(a[1:0]) + ref_size(c) > 4) return 3;
    return 2;
  endfunction

  function automatic void ref_store(input logic [2:0] c, input logic [31:0] a, input logic [31:0] d);
    for (int k = 0; k < ref_size(c); k++) begin
      ref_mem[(a + k) % NB] = d[8*k +: 8];
    end
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] c, input logic [31:0] a);
    longint v;
    int sz;
    sz = ref_size(c);
    v  = 0;
    for (int k = 0; k < sz; k++) begin
      v = v | (longint'(ref_mem[(a + k) % NB]) << (8 * k));
    end
    if ((c == 3'd0 || c == 3'd1) && (((v >> (8 * sz - 1)) & 1) == 1)) begin
      v = v - (longint'(1) << (8 * sz));
    end
    return v[31:0];
  endfunction

  // ---------------- helpers ----------------
  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h want=%h", nm, got, exp);
    end
  endtask

  // Starts and ends at a negedge. Returns response cycle index after E0
  // (0 if none within the bound) and whether rsp_valid was still high after.
  task automatic do_req(input logic rw, input logic [2:0] c, input logic [31:0] a,
                        input logic [31:0] d, output int lat, output logic [31:0] rd,
                        output logic er, output logic extra);
    int w;
    w = 0;
    while (!req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!req_ready) begin
      tests++;
      fails++;
      $display("FAIL ready_timeout got=0 want=1");
    end
    req_valid = 1'b1;
    mem_rw    = rw;
    whb       = c;
    addr      = a;
    wdata     = d;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    mem_rw    = 1'($urandom_range(1, 0));
    whb       = 3'($urandom_range(7, 0));
    addr      = $urandom();
    wdata     = $urandom();
    lat = 0;
    rd  = 32'd0;
    er  = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (rsp_valid) begin
        lat = k;
        rd  = rdata;
        er  = err;
        break;
      end
    end
    @(negedge clk);
    extra = rsp_valid;
  endtask

  task automatic run_checked(input string nm, input logic rw, input logic [2:0] c,
                             input logic [31:0] a, input logic [31:0] d, input logic chk_rd,
                             input logic [31:0] exp_rd, input logic exp_err, input int exp_lat);
    int lat;
    logic [31:0] rd;
    logic er;
    logic extra;
    do_req(rw, c, a, d, lat, rd, er, extra);
    check({nm, "_lat"}, 32'(lat), 32'(exp_lat));
    check({nm, "_err"}, {31'd0, er}, {31'd0, exp_err});
    check({nm, "_pulse"}, {31'd0, extra}, 32'd0);
    if (chk_rd) check({nm, "_rdata"}, rd, exp_rd);
    if (rw && ref_legal(rw, c)) ref_store(c, a, d);
  endtask

  // ---------------- test ----------------
  initial begin
    int lat;
    logic [31:0] rd;
    logic er;
    logic extra;
    logic [31:0] d;
    logic [31:0] pre24;

    tests     = 0;
    fails     = 0;
    rst       = 1'b1;
    req_valid = 1'b0;
    mem_rw    = 1'b0;
    whb       = 3'd0;
    addr      = 32'd0;
    wdata     = 32'd0;

    vecs.push_back('{"sw_aligned",  1'b1, 3'd2, 32'h0000_0010, 32'h1122_3344, 1'b0, 32'h0,          1'b0, 2});
    vecs.push_back('{"lw_aligned",  1'b0, 3'd2, 32'h0000_0010, 32'h0,         1'b1, 32'h1122_3344, 1'b0, 2});
    vecs.push_back('{"sb_13",       1'b1, 3'd0, 32'h0000_0013, 32'h0000_0080, 1'b0, 32'h0,          1'b0, 2});
    vecs.push_back('{"lb_13",       1'b0, 3'd0, 32'h0000_0013, 32'h0,         1'b1, 32'hFFFF_FF80, 1'b0, 2});
    vecs.push_back('{"lbu_13",      1'b0, 3'd3, 32'h0000_0013, 32'h0,         1'b1, 32'h0000_0080, 1'b0, 2});
    vecs.push_back('{"lw_after_sb", 1'b0, 3'd2, 32'h0000_0010, 32'h0,         1'b1, 32'h8022_3344, 1'b0, 2});
    vecs.push_back('{"sw_cross_0e", 1'b1, 3'd2, 32'h0000_000E, 32'hAABB_CCDD, 1'b0, 32'h0,          1'b0, 3});
    vecs.push_back('{"lw_10_cross", 1'b0, 3'd2, 32'h0000_0010, 32'h0,         1'b1, 32'h8022_AABB, 1'b0, 2});
    vecs.push_back('{"lh_0f",       1'b0, 3'd1, 32'h0000_000F, 32'h0,         1'b1, 32'hFFFF_BBCC, 1'b0, 3});
    vecs.push_back('{"lhu_11",      1'b0, 3'd4, 32'h0000_0011, 32'h0,         1'b1, 32'h0000_22AA, 1'b0, 2});
    vecs.push_back('{"sw_wrap",     1'b1, 3'd2, 32'h0000_0FFE, 32'h0102_0304, 1'b0, 32'h0,          1'b0, 3});
    vecs.push_back('{"lhu_ffe",     1'b0, 3'd4, 32'h0000_0FFE, 32'h0,         1'b1, 32'h0000_0304, 1'b0, 2});
    vecs.push_back('{"lhu_000",     1'b0, 3'd4, 32'h0000_0000, 32'h0,         1'b1, 32'h0000_0102, 1'b0, 2});
    vecs.push_back('{"lw_alias",    1'b0, 3'd2, 32'h0000_1010, 32'h0,         1'b1, 32'h8022_AABB, 1'b0, 2});
    vecs.push_back('{"ld_illegal",  1'b0, 3'd5, 32'h0000_0010, 32'h0,         1'b1, 32'h0,          1'b1, 1});
    vecs.push_back('{"st_illegal",  1'b1, 3'd3, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0,          1'b1, 1});
    vecs.push_back('{"lw_unchgd",   1'b0, 3'd2, 32'h0000_0010, 32'h0,         1'b1, 32'h8022_AABB, 1'b0, 2});

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_ready",     {31'd0, req_ready}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rdata",     rdata,              32'd0);
    check("rst_err",       {31'd0, err},       32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_release_ready", {31'd0, req_ready}, 32'd1);

    // Give every word a known value
    for (int i = 0; i < DEPTH; i++) begin
      d = $urandom();
      do_req(1'b1, 3'd2, 32'(i * 4), d, lat, rd, er, extra);
      ref_store(3'd2, 32'(i * 4), d);
    end

    // Directed vectors
    for (int i = 0; i < vecs.size(); i++) begin
      run_checked(vecs[i].name, vecs[i].rw, vecs[i].code, vecs[i].a, vecs[i].d,
                  vecs[i].chk_rd, vecs[i].exp_rd, vecs[i].exp_err, vecs[i].exp_lat);
    end

    // Reset during ACC1 of a crossing store to 0x22
    pre24 = ref_load(3'd4, 32'h24);
    begin
      int w;
      w = 0;
      while (!req_ready && w < 20) begin
        @(negedge clk);
        w++;
      end
    end
    check("mid_rst_ready_before", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    mem_rw    = 1'b1;
    whb       = 3'd2;
    addr      = 32'h22;
    wdata     = 32'hCAFE_F00D;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("mid_rst_rdata",     rdata,              32'd0);
    check("mid_rst_err",       {31'd0, err},       32'd0);
    check("mid_rst_ready_low", {31'd0, req_ready}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_ready_back", {31'd0, req_ready}, 32'd1);
    ref_mem[32'h22] = 8'h0D;
    ref_mem[32'h23] = 8'hF0;
    run_checked("mid_rst_lhu22", 1'b0, 3'd4, 32'h22, 32'h0, 1'b1, 32'h0000_F00D, 1'b0, 2);
    run_checked("mid_rst_lhu24", 1'b0, 3'd4, 32'h24, 32'h0, 1'b1, pre24,         1'b0, 2);

    // Randomized traffic against the reference model
    for (int i = 0; i < 300; i++) begin
      logic        rw;
      logic [2:0]  c;
      logic [31:0] a;
      logic [31:0] exp_rd;
      bit          legal;
      rw = 1'($urandom_range(1, 0));
      c  = 3'($urandom_range(7, 0));
      a  = ($urandom_range(1, 0) == 1) ? 32'($urandom_range(255, 0)) : $urandom();
      d  = $urandom();
      legal  = ref_legal(rw, c);
      exp_rd = (!rw && legal) ? ref_load(c, a) : 32'd0;
      run_checked("rand", rw, c, a, d, !(rw && legal), exp_rd, !legal, ref_lat(rw, c, a));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/data_mem_unit.md
# data_mem_unit

Data-memory responder for the single-cycle RISC-V core. It consumes the decoder's store enable and access-size code (`MemRW`, `whb`) together with the ALU address and the rs2 data, and serves byte, halfword and word loads and stores on an internal word array. It splits word-crossing misaligned accesses into two word cycles, sign- or zero-extends load data, and returns a one-cycle response pulse. It sits between the execute stage and the writeback mux input for `WBsel`=00.

## Interface
- `DEPTH_WORDS`, default 1024: number of 32-bit words. Must be a power of 2.
- `clk`: input, 1 bit. Single clock; all state updates on the rising edge.
- `rst`: input, 1 bit. Synchronous, active-high reset.
- `req_valid`: input, 1 bit. Request present.
- `req_ready`: output, 1 bit. Block accepts a request. Acceptance occurs on an edge where `req_valid` and `req_ready` are both 1.
- `MemRW`: input, 1 bit. 1 selects a store, 0 selects a load.
- `whb`: input, 3 bits. Access code.
  - Loads: 0=LB, 1=LH, 2=LW, 3=LBU, 4=LHU.
  - Stores: 0=SB, 1=SH, 2=SW.
- `addr`: input, 32 bits. Byte address.
- `wdata`: input, 32 bits. Store data, right-aligned.
- `rsp_valid`: output, 1 bit. One-cycle response pulse.
- `rdata`: output, 32 bits. Extended load data. Held between responses.
- `err`: output, 1 bit. Illegal access code. Valid with `rsp_valid`.

## Operation
- **Request capture:** `MemRW`, `whb`, `addr` and `wdata` are registered at acceptance. Inputs are ignored outside acceptance.
- **Address mapping:**
  - Word index = `addr[log2(DEPTH_WORDS)+1:2]`. Upper address bits are ignored (aliasing).
  - Byte offset = `addr[1:0]`.
  - Byte order is little-endian.
- **Access size:** size = 1 for codes 0/3, 2 for codes 1/4, 4 for code 2.
- **Word crossing:** an access crosses a word when offset + size > 4.
  - Affected cases: halfword at offset 3; word at offsets 1, 2 and 3.
  - The second word is index+1 mod `DEPTH_WORDS`. The last word wraps to word 0.
- **Illegal codes:** loads with `whb` 5–7 and stores with `whb` 3–7.
  - No memory effect.
  - Response has `err`=1 and `rdata`=0.
- **Stores:**
  - `wdata` byte k is written to byte address `addr`+k, for k < size.
  - Only the addressed byte lanes are written. Other lanes are preserved.
- **Loads:**
  - Bytes `addr`..`addr`+size-1 are assembled, with the lowest address in bits [7:0].
  - LB and LH sign-extend. LBU and LHU zero-extend. LW is passed unchanged.
- **Memory contents:** not cleared by `rst`.
- **FSM states:** IDLE, ACC0, ACC1, RESP.
  - IDLE: `req_ready`=1. On acceptance, go to RESP if the code is illegal, otherwise to ACC0.
  - ACC0: access the first word (read, or lane-masked write). Go to ACC1 if the access crosses, otherwise to RESP.
  - ACC1: access the second word. Go to RESP.
  - RESP: `rsp_valid`=1, with `rdata`/`err` valid. Go to IDLE.
- **Response path:** there is no response backpressure. The requester must sample in the pulse cycle.
- **Reset values:**
  - State = IDLE.
  - `req_ready`=0 while `rst` is 1, and 1 in the first cycle after `rst` deasserts.
  - `rsp_valid`=0, `rdata`=0, `err`=0.
- **Reset mid-operation:** the operation is aborted with no response.
  - Writes already committed stay in memory: the ACC0 word of a crossing store remains written if `rst` arrives during ACC1.
  - An uncommitted write is dropped.

## Timing
- The acceptance edge is E0.
- Aligned, or misaligned within one word:
  - ACC0 in the cycle after E0.
  - `rsp_valid`=1 in the second cycle after E0.
  - `req_ready` returns in the third cycle after E0.
- Crossing: one extra cycle. `rsp_valid` is high in the third cycle after E0.
- Illegal code: `rsp_valid` is high in the first cycle after E0.
- Throughput: one request per 3 cycles aligned, per 4 cycles crossing.
- Store commit: a store write commits on the edge ending its ACC cycle. A load accepted later observes it.
- `rdata` and `err` change only on the edge entering RESP, or on reset.

## Test plan
- **Aligned word:** SW `wdata`=0x11223344 to `addr`=0x10, then LW from 0x10.
  - Required: `rdata`=0x11223344, `err`=0, `rsp_valid` high exactly in cycle E0+2.
- **Byte store and extension:** SB `wdata`=0x00000080 to 0x13, then loads.
  - LB 0x13 → 0xFFFFFF80.
  - LBU 0x13 → 0x00000080.
  - LW 0x10 → 0x80223344.
- **Crossing word store:** SW 0xAABBCCDD to 0x0E.
  - Required: response at E0+3; LW 0x10 → 0x8022AABB; LH 0x0F → 0xFFFFBBCC, with response at E0+3.
  - LHU 0x11 → 0x000022AA, with response at E0+2 (no crossing).
- **Wrap and alias, `DEPTH_WORDS`=1024:** SW 0x01020304 to 0xFFE.
  - LHU 0xFFE → 0x00000304.
  - LHU 0x000 → 0x00000102.
  - LW 0x1010 returns the same value as LW 0x10.
- **Illegal code:** load with `whb`=5, then store with `whb`=3 to 0x10.
  - Required: each gives a response at E0+1 with `err`=1 and `rdata`=0.
  - LW 0x10 is unchanged afterwards.
- **Reset mid-operation:** assert `rst` during ACC1 of a crossing SW 0xCAFEF00D to 0x22.
  - Required: `rsp_valid`=0, `rdata`=0, `err`=0 after the reset edge; `req_ready` returns 1 one cycle after `rst` deasserts.
  - LHU 0x22 → 0x0000F00D.
  - LHU 0x24 returns its pre-store value.
